// File: rtl/vx_csr_io_pkg.sv
// Shared definitions for the CSR I/O bridge: op encoding and request layout.
// The bridge top optionally builds performance counters under CSR_IO_BRIDGE_PERF_EN.
package vx_csr_io_pkg;

    localparam int DEF_CSR_ADDR_BITS = 12;

    localparam logic CSR_IO_RD = 1'b0;
    localparam logic CSR_IO_WR = 1'b1;

    // Request entry as stored in the request FIFO, at the default address width.
    typedef struct packed {
        logic                         rw;
        logic [DEF_CSR_ADDR_BITS-1:0] addr;
        logic [31:0]                  data;
    } csr_io_req_t;

endpackage

// File: rtl/vx_csr_io_fifo.sv
// Generic synchronous FIFO, registered output, no bypass.
// Push is ignored when full and pop is ignored when empty, regardless of the other side.
module vx_csr_io_fifo #(
    parameter int DATAW = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [DATAW-1:0]       wdata,
    input  logic                   pop,
    output logic [DATAW-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DATAW-1:0] mem_q [DEPTH];
    logic [DATAW-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push & ~full;
        do_pop   = pop & ~empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/vx_csr_io_bridge.sv
// Host front end for the CSR unit I/O channel: request FIFO, credit-limited read issue,
// in-order response FIFO. Define CSR_IO_BRIDGE_PERF_EN to build the read/write fire counters.
module vx_csr_io_bridge
    import vx_csr_io_pkg::*;
#(
    parameter int REQ_DEPTH     = 4,
    parameter int RSP_DEPTH     = 4,
    parameter int CSR_ADDR_BITS = DEF_CSR_ADDR_BITS
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     host_req_valid,
    input  logic                     host_req_rw,
    input  logic [CSR_ADDR_BITS-1:0] host_req_addr,
    input  logic [31:0]              host_req_data,
    output logic                     host_req_ready,
    output logic                     csr_io_req_valid,
    output logic                     csr_io_req_rw,
    output logic [CSR_ADDR_BITS-1:0] csr_io_req_addr,
    output logic [31:0]              csr_io_req_data,
    input  logic                     csr_io_req_ready,
    input  logic                     csr_io_rsp_valid,
    input  logic [31:0]              csr_io_rsp_data,
    output logic                     csr_io_rsp_ready,
    output logic                     host_rsp_valid,
    output logic [31:0]              host_rsp_data,
    input  logic                     host_rsp_ready,
    output logic                     idle,
    output logic                     rsp_err,
    output logic [31:0]              perf_reads,
    output logic [31:0]              perf_writes
);

    // All handshakes: a transfer happens on the rising edge where valid & ready are both high;
    // valid never depends on ready, and the request payload is stable while valid is held.

    localparam int IW  = $clog2(RSP_DEPTH) + 1;
    localparam int RQC = $clog2(REQ_DEPTH) + 1;

    typedef struct packed {
        logic                     rw;
        logic [CSR_ADDR_BITS-1:0] addr;
        logic [31:0]              data;
    } req_t;

    req_t            req_wdata;
    req_t            req_head;
    logic            req_push;
    logic            req_full;
    logic            req_empty;
    logic [RQC-1:0]  req_count;

    logic            rsp_push;
    logic            rsp_pop;
    logic            rsp_full;
    logic            rsp_empty;
    logic [IW-1:0]   rsp_count;

    logic [IW-1:0]   inflight_q, inflight_d;
    logic            rsp_err_q, rsp_err_d;
    logic [IW:0]     credit_sum;
    logic            credit_ok;
    logic            fire;
    logic            rd_fire;
    logic            inflight_nz;

    assign req_wdata = '{rw: host_req_rw, addr: host_req_addr, data: host_req_data};
    assign req_push  = host_req_valid & ~req_full;

    vx_csr_io_fifo #(
        .DATAW ($bits(req_t)),
        .DEPTH (REQ_DEPTH)
    ) u_req_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (req_push),
        .wdata (req_wdata),
        .pop   (fire),
        .rdata (req_head),
        .full  (req_full),
        .empty (req_empty),
        .count (req_count)
    );

    vx_csr_io_fifo #(
        .DATAW (32),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (rsp_push),
        .wdata (csr_io_rsp_data),
        .pop   (rsp_pop),
        .rdata (host_rsp_data),
        .full  (rsp_full),
        .empty (rsp_empty),
        .count (rsp_count)
    );

    // A read may only issue if its response is guaranteed a slot in the response FIFO,
    // counting both reads still out at the CSR unit and data waiting for the host.
    assign credit_sum  = {1'b0, inflight_q} + {1'b0, rsp_count};
    assign credit_ok   = (credit_sum < (IW+1)'(RSP_DEPTH));
    assign inflight_nz = (inflight_q != '0);

    assign host_req_ready   = ~req_full;
    assign csr_io_req_valid = ~req_empty & ((req_head.rw == CSR_IO_WR) | credit_ok);
    assign csr_io_req_rw    = req_head.rw;
    assign csr_io_req_addr  = req_head.addr;
    assign csr_io_req_data  = req_head.data;
    assign fire             = csr_io_req_valid & csr_io_req_ready;
    assign rd_fire          = fire & (req_head.rw == CSR_IO_RD);

    assign csr_io_rsp_ready = ~rsp_full;
    assign rsp_push         = csr_io_rsp_valid & inflight_nz;
    assign host_rsp_valid   = ~rsp_empty;
    assign rsp_pop          = host_rsp_valid & host_rsp_ready;

    assign idle    = (req_count == '0) & (rsp_count == '0) & ~inflight_nz;
    assign rsp_err = rsp_err_q;

    always_comb begin
        inflight_d = inflight_q;
        case ({rd_fire, rsp_push})
            2'b10:   inflight_d = inflight_q + IW'(1);
            2'b01:   inflight_d = inflight_q - IW'(1);
            default: inflight_d = inflight_q;
        endcase
        // A response with nothing outstanding is dropped and latched as an error.
        rsp_err_d = rsp_err_q | (csr_io_rsp_valid & ~inflight_nz);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            inflight_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

`ifdef CSR_IO_BRIDGE_PERF_EN
    logic        wr_fire;
    logic [31:0] perf_reads_q, perf_reads_d;
    logic [31:0] perf_writes_q, perf_writes_d;

    assign wr_fire = fire & (req_head.rw == CSR_IO_WR);

    always_comb begin
        perf_reads_d  = perf_reads_q + {31'd0, rd_fire};
        perf_writes_d = perf_writes_q + {31'd0, wr_fire};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_reads_q  <= '0;
            perf_writes_q <= '0;
        end else begin
            perf_reads_q  <= perf_reads_d;
            perf_writes_q <= perf_writes_d;
        end
    end

    assign perf_reads  = perf_reads_q;
    assign perf_writes = perf_writes_q;
`else
    assign perf_reads  = '0;
    assign perf_writes = '0;
`endif

endmodule

// File: tb/tb_vx_csr_io_bridge.sv
// Bench for vx_csr_io_bridge: directed steps plus random traffic checked against a queue model.
module tb_vx_csr_io_bridge;

  localparam int REQ_DEPTH = 4;
  localparam int RSP_DEPTH = 4;
  localparam int AW        = 12;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          host_req_valid;
  logic          host_req_rw;
  logic [AW-1:0] host_req_addr;
  logic [31:0]   host_req_data;
  logic          host_req_ready;
  logic          csr_io_req_valid;
  logic          csr_io_req_rw;
  logic [AW-1:0] csr_io_req_addr;
  logic [31:0]   csr_io_req_data;
  logic          csr_io_req_ready;
  logic          csr_io_rsp_valid;
  logic [31:0]   csr_io_rsp_data;
  logic          csr_io_rsp_ready;
  logic          host_rsp_valid;
  logic [31:0]   host_rsp_data;
  logic          host_rsp_ready;
  logic          idle;
  logic          rsp_err;
  logic [31:0]   perf_reads;
  logic [31:0]   perf_writes;

  vx_csr_io_bridge #(
    .REQ_DEPTH     (REQ_DEPTH),
    .RSP_DEPTH     (RSP_DEPTH),
    .CSR_ADDR_BITS (AW)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .host_req_valid   (host_req_valid),
    .host_req_rw      (host_req_rw),
    .host_req_addr    (host_req_addr),
    .host_req_data    (host_req_data),
    .host_req_ready   (host_req_ready),
    .csr_io_req_valid (csr_io_req_valid),
    .csr_io_req_rw    (csr_io_req_rw),
    .csr_io_req_addr  (csr_io_req_addr),
    .csr_io_req_data  (csr_io_req_data),
    .csr_io_req_ready (csr_io_req_ready),
    .csr_io_rsp_valid (csr_io_rsp_valid),
    .csr_io_rsp_data  (csr_io_rsp_data),
    .csr_io_rsp_ready (csr_io_rsp_ready),
    .host_rsp_valid   (host_rsp_valid),
    .host_rsp_data    (host_rsp_data),
    .host_rsp_ready   (host_rsp_ready),
    .idle             (idle),
    .rsp_err          (rsp_err),
    .perf_reads       (perf_reads),
    .perf_writes      (perf_writes)
  );

  // scoreboard / reference model state
  int total = 0;
  int bad   = 0;
  logic [AW+32:0] exp_req_q[$];
  logic [31:0]    exp_q[$];
  int   tb_pend  = 0;
  logic exp_err  = 1'b0;
  bit   mv       = 1'b0;
  int   n_rd     = 0;
  int   n_wr     = 0;
  int   n_acc    = 0;
  int   m_reads  = 0;
  int   m_writes = 0;
  bit   auto_rsp = 1'b0;
  bit   rand_mode = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    exp_req_q.delete();
    exp_q.delete();
    tb_pend  = 0;
    exp_err  = 1'b0;
    m_reads  = 0;
    m_writes = 0;
  endtask

  // Monitor: compare outputs with the model, then apply this cycle's transfers.
  always @(negedge clk) begin
    bit m_vld, acc, fire, pop;
    if (!mv) begin
      if (reset) begin
        model_clear();
        mv = 1'b1;
      end
    end else begin
      m_vld = (exp_req_q.size() > 0) &&
              (exp_req_q[0][AW+32] || (tb_pend + exp_q.size() < RSP_DEPTH));
      chk("host_req_ready", host_req_ready, exp_req_q.size() < REQ_DEPTH);
      chk("csr_io_req_valid", csr_io_req_valid, m_vld);
      if (m_vld) begin
        chk("csr_io_req_rw", csr_io_req_rw, exp_req_q[0][AW+32]);
        chk("csr_io_req_addr", csr_io_req_addr, exp_req_q[0][AW+31:32]);
        chk("csr_io_req_data", csr_io_req_data, exp_req_q[0][31:0]);
      end
      chk("host_rsp_valid", host_rsp_valid, exp_q.size() > 0);
      if (exp_q.size() > 0) chk("host_rsp_data", host_rsp_data, exp_q[0]);
      chk("csr_io_rsp_ready", csr_io_rsp_ready, exp_q.size() < RSP_DEPTH);
      chk("idle", idle, (exp_req_q.size() == 0) && (exp_q.size() == 0) && (tb_pend == 0));
      chk("rsp_err", rsp_err, exp_err);
`ifdef CSR_IO_BRIDGE_PERF_EN
      chk("perf_reads", perf_reads, m_reads);
      chk("perf_writes", perf_writes, m_writes);
`else
      chk("perf_reads", perf_reads, 32'd0);
      chk("perf_writes", perf_writes, 32'd0);
`endif
      if (reset) begin
        model_clear();
      end else begin
        acc  = host_req_valid && (exp_req_q.size() < REQ_DEPTH);
        fire = m_vld && csr_io_req_ready;
        pop  = (exp_q.size() > 0) && host_rsp_ready;
        if (csr_io_rsp_valid) begin
          if (tb_pend > 0) begin
            exp_q.push_back(csr_io_rsp_data);
            tb_pend--;
          end else begin
            exp_err = 1'b1;
          end
        end
        if (pop) void'(exp_q.pop_front());
        if (fire) begin
          if (exp_req_q[0][AW+32]) begin
            n_wr++;
            m_writes++;
          end else begin
            n_rd++;
            m_reads++;
            tb_pend++;
          end
          void'(exp_req_q.pop_front());
        end
        if (acc) begin
          exp_req_q.push_back({host_req_rw, host_req_addr, host_req_data});
          n_acc++;
        end
      end
    end
  end

  // driver: advance one cycle, then update emulated CSR unit and random stimulus
  task automatic tick();
    @(posedge clk);
    #1;
    if (auto_rsp) begin
      if (tb_pend > 0 && (!rand_mode || $urandom_range(0, 1) == 1)) begin
        csr_io_rsp_valid = 1'b1;
        csr_io_rsp_data  = $urandom;
      end else begin
        csr_io_rsp_valid = 1'b0;
      end
    end
    if (rand_mode) begin
      host_req_valid   = 1'($urandom_range(0, 1));
      host_req_rw      = 1'($urandom_range(0, 1));
      host_req_addr    = AW'($urandom_range(0, 4095));
      host_req_data    = $urandom;
      csr_io_req_ready = ($urandom_range(0, 3) != 0);
      host_rsp_ready   = ($urandom_range(0, 2) != 0);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int r0, w0, a0;
    reset            = 1'b1;
    host_req_valid   = 1'b0;
    host_req_rw      = 1'b0;
    host_req_addr    = '0;
    host_req_data    = '0;
    csr_io_req_ready = 1'b0;
    csr_io_rsp_valid = 1'b0;
    csr_io_rsp_data  = '0;
    host_rsp_ready   = 1'b0;
    tick();
    tick();
    chk("rst_host_req_ready", host_req_ready, 1'b1);
    chk("rst_csr_io_req_valid", csr_io_req_valid, 1'b0);
    chk("rst_host_rsp_valid", host_rsp_valid, 1'b0);
    chk("rst_idle", idle, 1'b1);
    chk("rst_csr_io_rsp_ready", csr_io_rsp_ready, 1'b1);
    chk("rst_rsp_err", rsp_err, 1'b0);
    reset = 1'b0;
    tick();

    // single read of 0x300, CSR unit answers one cycle after fire
    r0 = n_rd;
    host_req_valid   = 1'b1;
    host_req_rw      = 1'b0;
    host_req_addr    = 12'h300;
    csr_io_req_ready = 1'b1;
    tick();
    host_req_valid = 1'b0;
    chk("t1_req_valid_latency", csr_io_req_valid, 1'b1);
    for (int i = 0; i < 10 && n_rd - r0 < 1; i++) tick();
    chk("t1_read_fired", n_rd - r0, 1);
    csr_io_rsp_valid = 1'b1;
    csr_io_rsp_data  = 32'h1234_5678;
    tick();
    csr_io_rsp_valid = 1'b0;
    chk("t1_host_rsp_valid", host_rsp_valid, 1'b1);
    chk("t1_host_rsp_data", host_rsp_data, 32'h1234_5678);
    host_rsp_ready = 1'b1;
    tick();
    host_rsp_ready = 1'b0;
    chk("t1_idle", idle, 1'b1);

    // four writes fill the request FIFO while the CSR unit stalls
    w0 = n_wr;
    a0 = n_acc;
    csr_io_req_ready = 1'b0;
    host_req_valid   = 1'b1;
    host_req_rw      = 1'b1;
    for (int i = 0; i < 6; i++) begin
      host_req_addr = AW'(12'h100 + i);
      host_req_data = $urandom;
      tick();
    end
    host_req_valid = 1'b0;
    chk("t2_accepts", n_acc - a0, 4);
    chk("t2_host_req_ready", host_req_ready, 1'b0);
    chk("t2_no_fire", n_wr - w0, 0);
    csr_io_req_ready = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    chk("t2_writes_fired", n_wr - w0, 4);
    chk("t2_idle", idle, 1'b1);

    // six reads against a stalled host: credits cap issue at four
    auto_rsp = 1'b1;
    r0 = n_rd;
    a0 = n_acc;
    host_req_valid = 1'b1;
    host_req_rw    = 1'b0;
    for (int i = 0; i < 40 && n_acc - a0 < 6; i++) begin
      host_req_addr = AW'($urandom_range(0, 4095));
      tick();
    end
    host_req_valid = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    chk("t3_reads_capped", n_rd - r0, 4);
    chk("t3_req_valid_low", csr_io_req_valid, 1'b0);
    host_rsp_ready = 1'b1;
    tick();
    host_rsp_ready = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("t3_one_more_read", n_rd - r0, 5);
    host_rsp_ready = 1'b1;
    for (int i = 0; i < 40 && !idle; i++) tick();
    chk("t3_drained", idle, 1'b1);
    host_rsp_ready = 1'b0;

    // read A then write B with no credits: B waits behind A
    r0 = n_rd;
    w0 = n_wr;
    a0 = n_acc;
    host_req_valid = 1'b1;
    for (int i = 0; i < 60 && n_acc - a0 < 6; i++) begin
      host_req_rw   = (n_acc - a0 == 5);
      host_req_addr = (n_acc - a0 == 4) ? 12'hA0A : (n_acc - a0 == 5) ? 12'hB0B : 12'h010;
      tick();
    end
    host_req_valid = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    chk("t4_reads_before", n_rd - r0, 4);
    chk("t4_write_blocked", n_wr - w0, 0);
    chk("t4_req_valid_low", csr_io_req_valid, 1'b0);
    host_rsp_ready = 1'b1;
    tick();
    host_rsp_ready = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("t4_read_a_fired", n_rd - r0, 5);
    chk("t4_write_b_fired", n_wr - w0, 1);
    host_rsp_ready = 1'b1;
    for (int i = 0; i < 40 && !idle; i++) tick();
    chk("t4_drained", idle, 1'b1);
    host_rsp_ready = 1'b0;

    // orphan response
    auto_rsp = 1'b0;
    csr_io_rsp_valid = 1'b1;
    csr_io_rsp_data  = 32'hDEAD_BEEF;
    tick();
    csr_io_rsp_valid = 1'b0;
    chk("t5_rsp_err", rsp_err, 1'b1);
    chk("t5_host_rsp_valid", host_rsp_valid, 1'b0);
    tick();
    chk("t5_rsp_err_sticky", rsp_err, 1'b1);

    // reset with two reads in flight and a queued write
    r0 = n_rd;
    a0 = n_acc;
    host_req_valid = 1'b1;
    host_req_rw    = 1'b0;
    for (int i = 0; i < 20 && n_acc - a0 < 2; i++) tick();
    host_req_valid = 1'b0;
    for (int i = 0; i < 20 && n_rd - r0 < 2; i++) tick();
    chk("t6_reads_out", n_rd - r0, 2);
    csr_io_req_ready = 1'b0;
    host_req_valid   = 1'b1;
    host_req_rw      = 1'b1;
    for (int i = 0; i < 20 && n_acc - a0 < 3; i++) tick();
    host_req_valid = 1'b0;
    chk("t6_busy", idle, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_idle_after_reset", idle, 1'b1);
    chk("t6_req_ready_after_reset", host_req_ready, 1'b1);
    chk("t6_err_cleared", rsp_err, 1'b0);
    csr_io_rsp_valid = 1'b1;
    csr_io_rsp_data  = $urandom;
    tick();
    csr_io_rsp_valid = 1'b0;
    chk("t6_late_rsp_err", rsp_err, 1'b1);
    chk("t6_late_rsp_dropped", host_rsp_valid, 1'b0);

    // randomized traffic against the model
    reset = 1'b1;
    tick();
    reset     = 1'b0;
    auto_rsp  = 1'b1;
    rand_mode = 1'b1;
    for (int i = 0; i < 800; i++) tick();
    rand_mode        = 1'b0;
    host_req_valid   = 1'b0;
    csr_io_req_ready = 1'b1;
    host_rsp_ready   = 1'b1;
    for (int i = 0; i < 100 && !idle; i++) tick();
    chk("rand_drained", idle, 1'b1);
    chk("rand_model_empty", exp_q.size() + exp_req_q.size() + tb_pend, 0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
